lc3b_control: RTL
=================

Name: lc3b_control

Overview:
Multi-cycle control FSM for the LC-3b datapath.
- Sequences fetch, decode and execute by driving every datapath load and mux-select signal.
- Issues memory read/write strobes and waits on the memory response handshake.
- Sits between the datapath (consumes opcode, br_enable, ir_imm) and the memory port.

Parameters:
TIMEOUT_CYCLES, 255, max cycles a memory state waits for mem_resp (used only with MEM_TIMEOUT_EN).

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous active-high reset; forces state FETCH1
opcode  input  4  lc3b_opcode from IR
br_enable  input  1  cccomp result (IR nzp AND current cc nonzero)
ir_imm  input  1  IR[5]; 1 = ADD/AND immediate form
mem_resp  input  1  memory done; read data valid / write accepted this cycle
load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc  output  1 each  datapath register loads
pcmux_sel  output  2  0=pc+2, 1=br_add, 2=alu_out
storemux_sel  output  1  0=sr1, 1=dest (STR source)
alumux_sel  output  2  0=sr2_out, 1=adj6, 2=imm5 sign-extended
regfilemux_sel  output  2  0=alu_out, 1=mdr_out, 2=br_add
marmux_sel  output  1  0=alu_out, 1=pc_out
mdrmux_sel  output  1  0=alu_out, 1=mem_rdata
aluop  output  lc3b_aluop  alu_add/alu_and/alu_not/alu_pass
mem_read, mem_write  output  1 each  memory strobes, held until mem_resp
mem_byte_enable  output  2  always 2'b11 (word accesses only)
mem_err  output  1  sticky timeout flag (0 when feature compiled out)

Behaviour:
- Moore FSM; outputs are a combinational function of state only.
- Every output defaults to 0 in each state, except mem_byte_enable = 2'b11 and aluop = alu_add.
- Reset (asynchronous, any cycle, including mid-memory-wait) -> FETCH1 and mem_err = 0.
- Outputs during reset equal the FETCH1 values: marmux_sel=1, load_mar=1, all others 0.
- FETCH1: marmux_sel=1, load_mar=1 -> FETCH2.
- FETCH2: mem_read=1, mdrmux_sel=1, load_mdr=1; stay until mem_resp=1 -> FETCH3.
- FETCH3: load_ir=1, pcmux_sel=0, load_pc=1 (PC += 2) -> DECODE.
- DECODE: no loads. Next state by opcode:
  - ADD -> S_ADD; AND -> S_AND; NOT -> S_NOT
  - BR -> S_BR; LDR, STR -> CALC_ADDR; JMP -> S_JMP; LEA -> S_LEA
  - any other opcode -> FETCH1 (treated as NOP; PC already advanced)
- S_ADD / S_AND: aluop=add/and; alumux_sel = ir_imm ? 2 : 0; regfilemux_sel=0; load_regfile=1; load_cc=1 -> FETCH1.
- S_NOT: aluop=alu_not, load_regfile=1, load_cc=1 -> FETCH1.
- S_BR: if br_enable -> BR_TAKEN, else -> FETCH1 (branch not taken).
- BR_TAKEN: pcmux_sel=1, load_pc=1 -> FETCH1.
- S_JMP: aluop=alu_pass, pcmux_sel=2, load_pc=1 -> FETCH1.
- S_LEA: regfilemux_sel=2, load_regfile=1, load_cc=1 -> FETCH1.
- CALC_ADDR: alumux_sel=1, aluop=alu_add, marmux_sel=0, load_mar=1 -> LDR1 if opcode==LDR, else STR1.
- LDR1: mem_read=1, mdrmux_sel=1, load_mdr=1; wait for mem_resp -> LDR2.
- LDR2: regfilemux_sel=1, load_regfile=1, load_cc=1 -> FETCH1.
- STR1: storemux_sel=1, aluop=alu_pass, mdrmux_sel=0, load_mdr=1 -> STR2.
- STR2: mem_write=1, storemux_sel=1; wait for mem_resp -> FETCH1.
- mem_resp is ignored in every state that is not a memory-wait state.
- Latency: ADD/AND/NOT/JMP/LEA = 5 cycles with a 1-cycle memory response.
  - BR = 5 cycles not taken, 6 taken.
  - LDR = 7 cycles; STR = 7 cycles.

Optional Feature:
Macro MEM_TIMEOUT_EN.
- When defined:
  - An 8-bit wait counter clears on entry to FETCH2, LDR1 or STR2 and increments each cycle mem_resp=0.
  - When the count reaches TIMEOUT_CYCLES, set mem_err=1 and move to state HALT.
  - HALT: all outputs 0 (incl. strobes), stays until reset.
- When undefined: no counter, no HALT state; memory states wait indefinitely; mem_err tied to 0.

Test Plan:
- Reset asserted mid-FETCH2 (mem_read=1) -> same cycle mem_read=0, load_mar=1, marmux_sel=1; after release, FETCH1 -> FETCH2.
- ADD R1,R2,#3 (ir_imm=1), mem_resp delayed 3 cycles in FETCH2 -> mem_read held 4 cycles; S_ADD shows alumux_sel=2, load_regfile=1, load_cc=1.
- BR with br_enable=0 -> DECODE, S_BR, FETCH1, no load_pc beyond FETCH3; br_enable=1 -> BR_TAKEN with pcmux_sel=1, load_pc=1.
- LDR, 1-cycle memory -> CALC_ADDR (marmux_sel=0, alumux_sel=1), then LDR1, then LDR2 (regfilemux_sel=1); 7 cycles total.
- STR -> STR1 with mdrmux_sel=0, storemux_sel=1; STR2 with mem_write=1 held until mem_resp, then FETCH1.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_resp never set -> mem_err=1 after 4 FETCH2 cycles; FSM in HALT with all strobes 0 until reset.

Source files
------------

// File: rtl/lc3b_control.sv
// Multi-cycle Moore control FSM for the LC-3b datapath: fetch/decode/execute sequencing.
// Optional MEM_TIMEOUT_EN adds a memory-wait watchdog that parks the FSM in HALT.
module lc3b_control #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] opcode,
   input  logic       br_enable,
   input  logic       ir_imm,
   input  logic       mem_resp,
   output logic       load_pc,
   output logic       load_ir,
   output logic       load_regfile,
   output logic       load_mar,
   output logic       load_mdr,
   output logic       load_cc,
   output logic [1:0] pcmux_sel,
   output logic       storemux_sel,
   output logic [1:0] alumux_sel,
   output logic [1:0] regfilemux_sel,
   output logic       marmux_sel,
   output logic       mdrmux_sel,
   output logic [1:0] aluop,
   output logic       mem_read,
   output logic       mem_write,
   output logic [1:0] mem_byte_enable,
   output logic       mem_err
);

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_LEA = 4'b1110;

   localparam logic [1:0] ALU_ADD  = 2'd0;
   localparam logic [1:0] ALU_AND  = 2'd1;
   localparam logic [1:0] ALU_NOT  = 2'd2;
   localparam logic [1:0] ALU_PASS = 2'd3;

   typedef enum logic [4:0] {
      FETCH1, FETCH2, FETCH3, DECODE,
      S_ADD, S_AND, S_NOT, S_BR, BR_TAKEN, S_JMP, S_LEA,
      CALC_ADDR, LDR1, LDR2, STR1, STR2
`ifdef MEM_TIMEOUT_EN
      , HALT
`endif
   } state_t;

   state_t state, next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH1;
      else       state <= next;
   end

`ifdef MEM_TIMEOUT_EN
   logic [7:0] wait_cnt;
   logic       err_q;
   logic       mem_wait;

   assign mem_wait = (state == FETCH2) || (state == LDR1) || (state == STR2);
   assign mem_err  = err_q;

   // Any state change clears the counter, so it reads 0 on the first cycle of each wait.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (next == HALT) err_q <= 1'b1;
         if (state != next)              wait_cnt <= '0;
         else if (mem_wait && !mem_resp) wait_cnt <= wait_cnt + 8'd1;
      end
   end
`else
   assign mem_err = 1'b0;
`endif

   always_comb begin
      next            = state;
      load_pc         = 1'b0;
      load_ir         = 1'b0;
      load_regfile    = 1'b0;
      load_mar        = 1'b0;
      load_mdr        = 1'b0;
      load_cc         = 1'b0;
      pcmux_sel       = 2'd0;
      storemux_sel    = 1'b0;
      alumux_sel      = 2'd0;
      regfilemux_sel  = 2'd0;
      marmux_sel      = 1'b0;
      mdrmux_sel      = 1'b0;
      aluop           = ALU_ADD;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_byte_enable = 2'b11;

      unique case (state)
         FETCH1: begin
            marmux_sel = 1'b1;
            load_mar   = 1'b1;
            next       = FETCH2;
         end
         FETCH2: begin
            mem_read   = 1'b1;
            mdrmux_sel = 1'b1;
            load_mdr   = 1'b1;
            if (mem_resp) next = FETCH3;
         end
         FETCH3: begin
            load_ir = 1'b1;
            load_pc = 1'b1;
            next    = DECODE;
         end
         DECODE: begin
            case (opcode)
               OP_ADD:         next = S_ADD;
               OP_AND:         next = S_AND;
               OP_NOT:         next = S_NOT;
               OP_BR:          next = S_BR;
               OP_LDR, OP_STR: next = CALC_ADDR;
               OP_JMP:         next = S_JMP;
               OP_LEA:         next = S_LEA;
               default:        next = FETCH1;
            endcase
         end
         S_ADD, S_AND: begin
            aluop        = (state == S_AND) ? ALU_AND : ALU_ADD;
            alumux_sel   = ir_imm ? 2'd2 : 2'd0;
            load_regfile = 1'b1;
            load_cc      = 1'b1;
            next         = FETCH1;
         end
         S_NOT: begin
            aluop        = ALU_NOT;
            load_regfile = 1'b1;
            load_cc      = 1'b1;
            next         = FETCH1;
         end
         S_BR:     next = br_enable ? BR_TAKEN : FETCH1;
         BR_TAKEN: begin
            pcmux_sel = 2'd1;
            load_pc   = 1'b1;
            next      = FETCH1;
         end
         S_JMP: begin
            aluop     = ALU_PASS;
            pcmux_sel = 2'd2;
            load_pc   = 1'b1;
            next      = FETCH1;
         end
         S_LEA: begin
            regfilemux_sel = 2'd2;
            load_regfile   = 1'b1;
            load_cc        = 1'b1;
            next           = FETCH1;
         end
         CALC_ADDR: begin
            alumux_sel = 2'd1;
            load_mar   = 1'b1;
            next       = (opcode == OP_LDR) ? LDR1 : STR1;
         end
         LDR1: begin
            mem_read   = 1'b1;
            mdrmux_sel = 1'b1;
            load_mdr   = 1'b1;
            if (mem_resp) next = LDR2;
         end
         LDR2: begin
            regfilemux_sel = 2'd1;
            load_regfile   = 1'b1;
            load_cc        = 1'b1;
            next           = FETCH1;
         end
         STR1: begin
            storemux_sel = 1'b1;
            aluop        = ALU_PASS;
            load_mdr     = 1'b1;
            next         = STR2;
         end
         STR2: begin
            mem_write    = 1'b1;
            storemux_sel = 1'b1;
            if (mem_resp) next = FETCH1;
         end
`ifdef MEM_TIMEOUT_EN
         HALT: mem_byte_enable = 2'b00;
`endif
         default: next = FETCH1;
      endcase

`ifdef MEM_TIMEOUT_EN
      if (mem_wait && !mem_resp && wait_cnt == 8'(TIMEOUT_CYCLES - 1)) next = HALT;
`endif
   end

endmodule
